// File: rtl/parking_gate_controller_if.sv
// Signal bundle between the parking barrier controller and its surroundings:
// request buttons, the outer/inner sensor pair, occupancy in, gate commands out.
interface parking_gate_controller_if;
  logic       entry_req;
  logic       exit_req;
  logic       outer;
  logic       inner;
  logic [4:0] car_count;
  logic       gate_open;
  logic       entry_grant;
  logic       exit_grant;
  logic       full;
  logic       busy;
  logic       timeout_err;

  // Environment side: drives requests, sensors and occupancy.
  modport master (
    output entry_req, exit_req, outer, inner, car_count,
    input  gate_open, entry_grant, exit_grant, full, busy, timeout_err
  );

  // Controller side.
  modport slave (
    input  entry_req, exit_req, outer, inner, car_count,
    output gate_open, entry_grant, exit_grant, full, busy, timeout_err
  );
endinterface

// File: rtl/parking_gate_controller.sv
// Single-lane barrier sequencer. Arbitrates entry (outer side) against exit
// (inner side) round-robin, refuses entry at capacity, follows the car
// through the sensor pair and holds the gate closed briefly between cars.
module parking_gate_controller #(
  parameter int CAPACITY = 16,
  parameter int TIMEOUT  = 8,
  parameter int HOLDOFF  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  parking_gate_controller_if.slave    gate_if
);

  localparam int TMAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_IN,
    PASS_IN,
    GRANT_OUT,
    PASS_OUT,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic          last_served_q, last_served_d;   // 0 = entry, 1 = exit
  logic          far_seen_q, far_seen_d;         // car reached the far sensor
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_err_q, timeout_err_d;

  logic          full;
  logic          entry_ok;
  logic          exit_ok;
  logic [TW-1:0] timer_inc;

  // Occupancy limit is the only combinational output.
  assign full     = (32'(gate_if.car_count) >= 32'(CAPACITY));
  assign entry_ok = gate_if.entry_req && !full;
  assign exit_ok  = gate_if.exit_req;
  // Timer saturates at its largest useful value instead of wrapping.
  assign timer_inc = (timer_q == TW'(TMAX)) ? timer_q : timer_q + TW'(1);

  // State and flag registers; reset drops the gate immediately with no HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      far_seen_q    <= 1'b0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      far_seen_q    <= far_seen_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic: arbitration in IDLE, sensor tracking in GRANT/PASS.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    far_seen_d    = far_seen_q;
    timer_d       = timer_q;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        // last_served=1 means exit went last, so entry wins a tie.
        if (entry_ok && (!exit_ok || last_served_q)) begin
          state_d = GRANT_IN;
        end else if (exit_ok) begin
          state_d = GRANT_OUT;
        end
      end

      GRANT_IN: begin
        // Only the outer sensor starts an entry; inner first is ignored.
        if (gate_if.outer) begin
          state_d       = PASS_IN;
          far_seen_d    = 1'b0;
          last_served_d = 1'b0;
        end else if (timer_inc == TW'(TIMEOUT)) begin
          state_d       = HOLD;
          timeout_err_d = 1'b1;
          timer_d       = '0;
          last_served_d = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end

      PASS_IN: begin
        if (gate_if.inner) begin
          far_seen_d = 1'b1;
        end
        // Both clear ends the pass, whether the car got through or backed out.
        if (!gate_if.outer && !gate_if.inner) begin
          state_d       = HOLD;
          timer_d       = '0;
          last_served_d = 1'b0;
        end
      end

      GRANT_OUT: begin
        if (gate_if.inner) begin
          state_d       = PASS_OUT;
          far_seen_d    = 1'b0;
          last_served_d = 1'b1;
        end else if (timer_inc == TW'(TIMEOUT)) begin
          state_d       = HOLD;
          timeout_err_d = 1'b1;
          timer_d       = '0;
          last_served_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      PASS_OUT: begin
        if (gate_if.outer) begin
          far_seen_d = 1'b1;
        end
        if (!gate_if.outer && !gate_if.inner) begin
          state_d       = HOLD;
          timer_d       = '0;
          last_served_d = 1'b1;
        end
      end

      HOLD: begin
        if (timer_inc >= TW'(HOLDOFF)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign gate_if.gate_open   = (state_q == GRANT_IN)  || (state_q == PASS_IN) ||
                               (state_q == GRANT_OUT) || (state_q == PASS_OUT);
  assign gate_if.entry_grant = (state_q == GRANT_IN)  || (state_q == PASS_IN);
  assign gate_if.exit_grant  = (state_q == GRANT_OUT) || (state_q == PASS_OUT);
  assign gate_if.busy        = (state_q != IDLE);
  assign gate_if.timeout_err = timeout_err_q;
  assign gate_if.full        = full;

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Sequences the single-lane barrier gate of the parking lot and arbitrates it between entry requests (outer side) and exit requests (inner side). It reads the occupancy from `car_counter` and refuses entry at capacity. It opens the gate for one granted direction at a time and tracks the car through the outer/inner sensor pair. The gate closes once the car has cleared.

## Interface
- `CAPACITY`, default 16: occupancy at which entry is refused.
- `TIMEOUT`, default 8: cycles a grant waits for the first sensor before abandoning.
- `HOLDOFF`, default 2: closed-gate cycles after each transaction before the next grant.
- `clk` in 1: system clock (CLOCK_50 at top level).
- `reset` in 1: synchronous, active-high reset.
- `entry_req` in 1: level; car waiting at the outer ticket button.
- `exit_req` in 1: level; car waiting at the inner card reader.
- `outer` in 1: outer sensor, 1 = blocked.
- `inner` in 1: inner sensor, 1 = blocked.
- `car_count` in 5: current occupancy from `car_counter`.
- `gate_open` out 1: barrier raise command.
- `entry_grant` out 1: entry direction lamp.
- `exit_grant` out 1: exit direction lamp.
- `full` out 1: `car_count >= CAPACITY`.
- `busy` out 1: state is not IDLE.
- `timeout_err` out 1: one-cycle pulse when a grant expires unused.

## Operation
- States: IDLE, GRANT_IN, PASS_IN, GRANT_OUT, PASS_OUT, HOLD.
- Registers:
  - `last_served` (0 = entry, 1 = exit).
  - `far_seen` flag.
  - Timer, `$clog2(max(TIMEOUT,HOLDOFF)+1)` bits, saturating, never wraps.
- `full` is combinational from `car_count`. It is the only combinational output; all others are decoded from registered state/flags.
- IDLE arbitration:
  - Entry is eligible when `entry_req && !full`. Exit is eligible when `exit_req`.
  - If only one is eligible, grant it.
  - If both are eligible, grant the direction opposite `last_served` (round-robin).
  - Requests are levels and are not latched. An entry request during `full` is ignored, not queued.
- GRANT_IN:
  - Outputs: `gate_open=1`, `entry_grant=1`. The timer counts up.
  - If `outer` goes high: go to PASS_IN, clear `far_seen`.
  - Else, if the timer reaches TIMEOUT: pulse `timeout_err` and go to HOLD.
- PASS_IN:
  - Outputs: `gate_open=1`, `entry_grant=1`.
  - Set `far_seen` when `inner` is high.
  - When `outer=0 && inner=0`, go to HOLD. This applies both when `far_seen` is set (completed entry) and when it is clear (car backed out; no error).
- GRANT_OUT and PASS_OUT mirror the entry states with `inner`/`outer` swapped and `exit_grant` asserted.
- `last_served` updates on leaving any GRANT or PASS state, including on timeout.
- HOLD:
  - Outputs: `gate_open=0`, grants 0.
  - Stay HOLDOFF cycles, then go to IDLE.
- The controller never modifies `car_count`. Counting stays in `car_counter`, which observes the same sensors.
- A sensor activating in the wrong order for the grant (e.g. `inner` first during GRANT_IN) is not a start. The state stays in GRANT and the timer keeps running.

## Timing
- Reset (synchronous, at a clk edge with `reset=1`):
  - State IDLE, `last_served=1` (so entry wins the first tie), timer 0, `far_seen=0`.
  - `gate_open`, `entry_grant`, `exit_grant`, `busy`, `timeout_err` all 0.
- Reset mid-transaction takes effect at that edge. The gate drops in the same cycle, with no HOLD.
- Latency:
  - A request sampled in IDLE at edge N gives grant and `gate_open` high after edge N (visible in cycle N+1).
  - The start sensor sampled high at edge M moves the state to PASS after M.
  - Both sensors low sampled at edge K: `gate_open` is 0 after K.
  - IDLE is re-entered HOLDOFF cycles later. The earliest next grant is HOLDOFF+1 cycles after K.
- Timeout: with no start sensor, `timeout_err` is high for exactly one cycle, TIMEOUT cycles after the grant rose. The gate falls in that same cycle.
- A `full` change while already in GRANT_IN or PASS_IN does not revoke the grant.
- Simultaneous requests in the same cycle are resolved only by `last_served`.

## Test plan
- Reset, then `entry_req=1` with `car_count=0`:
  - `entry_grant` and `gate_open` rise one cycle later.
  - Drive `outer` 1 → 1,1 → 0,1 → 0,0: gate closes on the first 0,0 cycle, `busy` falls after 2 HOLD cycles.
- `entry_req=exit_req=1` held through three transactions: grants go entry, exit, entry.
- `car_count=16`, `entry_req=exit_req=1`: only `exit_grant` asserts, `full=1`. After `car_count` drops to 15, entry is granted next.
- `exit_req=1`, no sensor activity: `timeout_err` is a 1-cycle pulse 8 cycles after the grant, gate closes. A subsequent tie goes to entry.
- Entry granted, `outer` 1 then 0 with `inner` never high (back-out): returns to HOLD, no `timeout_err`.
- Assert `reset` during PASS_OUT: all outputs 0 on the next cycle, state IDLE, the next tie grants entry.
